// File: rtl/nn_sample_sequencer.sv
// nn_sample_sequencer: on-chip dataset player for the BackPropagationNN core.
// A host loads a table of {x0,x1,x2,x3,desired_y0,desired_y1} samples. Each
// sample is presented to the NN for HOLD_CYCLES clocks. At the end of that
// window the NN outputs are scored by sign against the desired targets.
// Per-sample period: FETCH (1) + HOLD (HOLD_CYCLES) + CHECK (1).
// Optional build macro: NN_SEQ_CONTINUOUS_EN. When it is defined, passes loop
// back to sample 0, and a start pulse while busy stops the block after the
// current CHECK.
module nn_sample_sequencer #(
    parameter int DEPTH       = 200,
    parameter int ADDR_W      = 8,
    parameter int D_W         = 9,
    parameter int Y_W         = 256,
    parameter int HOLD_CYCLES = 24
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_we,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [6*D_W-1:0]      load_data,
    input  logic [ADDR_W:0]       num_samples,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic signed [D_W-1:0] x0,
    output logic signed [D_W-1:0] x1,
    output logic signed [D_W-1:0] x2,
    output logic signed [D_W-1:0] x3,
    output logic signed [D_W-1:0] desired_y0,
    output logic signed [D_W-1:0] desired_y1,
    input  logic signed [Y_W-1:0] y0,
    input  logic signed [Y_W-1:0] y1,
    output logic [ADDR_W-1:0]     sample_idx,
    output logic [15:0]           err_count,
    output logic [15:0]           epoch
);

    localparam int HC_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Strictly positive test on a signed D_W value.
    function automatic logic is_pos_d(input logic [D_W-1:0] v);
        return (~v[D_W-1]) & (|v);
    endfunction

    // Strictly positive test on a signed Y_W value.
    function automatic logic is_pos_y(input logic [Y_W-1:0] v);
        return (~v[Y_W-1]) & (|v);
    endfunction

    // Add a 0..2 mismatch count to the accumulator. The result saturates at all-ones.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t              state_r, state_nxt_s;
    logic [HC_W-1:0]     hold_cnt_r;
    logic [ADDR_W-1:0]   last_idx_r;
    logic [6*D_W-1:0]    mem_r [DEPTH];
    logic [6*D_W-1:0]    rd_data_r;
    logic                y0_pos_r, y1_pos_r;
    logic [15:0]         acc_r;
    logic [ADDR_W:0]     num_clamp_s;
    logic                idle_like_s, start_ok_s, num_zero_s, is_last_s, hold_end_s;
    logic                empty_pass_s, load_x_s, check_s, pass_end_s;
    logic [1:0]          miss_s;
    logic [15:0]         acc_sum_s;
`ifdef NN_SEQ_CONTINUOUS_EN
    logic                stop_req_r;
    logic                stop_now_s;
`endif

    // Control decode: start qualification, window end, last sample, scoring.
    always_comb begin
        idle_like_s  = (state_r == S_IDLE) || (state_r == S_DONE);
        num_clamp_s  = (num_samples > DEPTH_L) ? DEPTH_L : num_samples;
        num_zero_s   = (num_clamp_s == (ADDR_W + 1)'(0));
        start_ok_s   = start & idle_like_s;
        empty_pass_s = start_ok_s & num_zero_s;
        is_last_s    = (sample_idx == last_idx_r);
        hold_end_s   = (hold_cnt_r == HOLD_LAST);
        load_x_s     = (state_r == S_HOLD) && (hold_cnt_r == HC_W'(0));
        check_s      = (state_r == S_CHECK);
        pass_end_s   = check_s & is_last_s;
        miss_s       = {1'b0, y0_pos_r ^ is_pos_d(desired_y0)}
                     + {1'b0, y1_pos_r ^ is_pos_d(desired_y1)};
        acc_sum_s    = sat_add(acc_r, miss_s);
`ifdef NN_SEQ_CONTINUOUS_EN
        stop_now_s   = stop_req_r | start;
`endif
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_ok_s) begin
                    state_nxt_s = num_zero_s ? S_DONE : S_FETCH;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_FETCH: state_nxt_s = S_HOLD;
            S_HOLD: begin
                if (hold_end_s) begin
                    state_nxt_s = S_CHECK;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_CHECK: begin
`ifdef NN_SEQ_CONTINUOUS_EN
                if (stop_now_s) begin
`else
                if (is_last_s) begin
`endif
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold-window counter, running 0..HOLD_CYCLES-1 while in HOLD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_cnt_r <= HC_W'(0);
        end else if ((state_r == S_HOLD) && !hold_end_s) begin
            hold_cnt_r <= hold_cnt_r + HC_W'(1);
        end else begin
            hold_cnt_r <= HC_W'(0);
        end
    end

    // Status outputs, sample index, pass length, error accumulation and epoch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_idx <= ADDR_W'(0);
            last_idx_r <= ADDR_W'(0);
            acc_r      <= 16'd0;
            err_count  <= 16'd0;
            epoch      <= 16'd0;
        end else begin
            busy <= (state_nxt_s == S_FETCH) || (state_nxt_s == S_HOLD) || (state_nxt_s == S_CHECK);
            done <= (state_nxt_s == S_DONE);
            if (start_ok_s) begin
                sample_idx <= ADDR_W'(0);
                last_idx_r <= ADDR_W'(num_clamp_s - (ADDR_W + 1)'(1));
                acc_r      <= 16'd0;
                err_count  <= 16'd0;
            end else if (check_s) begin
                if (state_nxt_s == S_FETCH) begin
                    sample_idx <= is_last_s ? ADDR_W'(0) : sample_idx + ADDR_W'(1);
                end
`ifdef NN_SEQ_CONTINUOUS_EN
                // Publish the epoch's total and restart the accumulator at each pass boundary or stop.
                if (pass_end_s || stop_now_s) begin
                    err_count <= acc_sum_s;
                    acc_r     <= 16'd0;
                end else begin
                    acc_r     <= acc_sum_s;
                end
`else
                acc_r     <= acc_sum_s;
                err_count <= acc_sum_s;
`endif
            end
            if (empty_pass_s || pass_end_s) begin
                epoch <= epoch + 16'd1;
            end
        end
    end

`ifdef NN_SEQ_CONTINUOUS_EN
    // Latch a stop request from a start pulse that arrives while a pass is running.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stop_req_r <= 1'b0;
        end else if (start_ok_s || (state_nxt_s == S_DONE)) begin
            stop_req_r <= 1'b0;
        end else if (start && !idle_like_s) begin
            stop_req_r <= 1'b1;
        end
    end
`endif

    // Present the fetched sample at HOLD entry. Register the NN output signs for CHECK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x0         <= '0;
            x1         <= '0;
            x2         <= '0;
            x3         <= '0;
            desired_y0 <= '0;
            desired_y1 <= '0;
            y0_pos_r   <= 1'b0;
            y1_pos_r   <= 1'b0;
        end else begin
            y0_pos_r <= is_pos_y(y0);
            y1_pos_r <= is_pos_y(y1);
            if (load_x_s) begin
                x0         <= rd_data_r[6*D_W-1 -: D_W];
                x1         <= rd_data_r[5*D_W-1 -: D_W];
                x2         <= rd_data_r[4*D_W-1 -: D_W];
                x3         <= rd_data_r[3*D_W-1 -: D_W];
                desired_y0 <= rd_data_r[2*D_W-1 -: D_W];
                desired_y1 <= rd_data_r[D_W-1:0];
            end
        end
    end

    // Sample table writes. Only accepted while no pass is running and the address is in range.
    always_ff @(posedge CLK) begin
        if (load_we && idle_like_s && ({1'b0, load_addr} < DEPTH_L)) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Synchronous table read, issued in FETCH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data_r <= '0;
        end else if (state_r == S_FETCH) begin
            rd_data_r <= mem_r[sample_idx];
        end
    end

endmodule
